// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO for uart_rx: DEPTH entries, wrapping pointers, occupancy counter.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head_data,
  output logic       full,
  output logic       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronized rxd, midpoint sampling FSM, byte storage with overrun.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise storage is one holding register.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge
// START     | half-bit wait, then confirm the start bit is still low
// DATA      | sampling 8 data bits at bit midpoints, LSB first
// STOP      | one-bit wait, then check the stop bit
// WAIT_IDLE | framing error seen, waiting for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int TMR_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TMR_W-1:0] TMR_BIT  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLKS_PER_BIT / 2 - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx: FIFO_DEPTH must be a power of two, at least 2");
  end

  logic       rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic [1:0] settle_q, settle_d;
  logic       fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      settle_q   <= '0;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
      settle_q   <= settle_d;
    end
  end

  // Edges are ignored until the reset-forced 1s have flushed out of the pipeline,
  // so a line that is already low at reset release cannot fake a start bit.
  assign settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
  assign fall     = (settle_q == 2'd3) & rxd_prev_q & ~rxd_sync_q;

  uart_state_e      state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic             push;

  assign push = (state_q == STOP) && (tmr_q == '0) && rxd_sync_q;

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d   = START;
          tmr_d     = TMR_HALF;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else if (!rxd_sync_q) begin
          state_d = DATA;
          tmr_d   = TMR_BIT;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else begin
          shift_d   = {rxd_sync_q, shift_q[7:1]};
          tmr_d     = TMR_BIT;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else if (rxd_sync_q) begin
          state_d = IDLE;
        end else begin
          state_d     = WAIT_IDLE;
          frame_err_d = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rxd_sync_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  logic pop, full;
  logic overrun_q, overrun_d;

  assign pop = rx_valid & rx_ready;

`ifdef UART_RX_FIFO_EN
  logic empty;

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(shift_q),
    .pop      (pop),
    .head_data(rx_data),
    .full     (full),
    .empty    (empty)
  );

  assign rx_valid = ~empty;
`else
  logic [7:0] hold_data_q, hold_data_d;
  logic       hold_valid_q, hold_valid_d;

  always_comb begin
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    if (pop) begin
      hold_valid_d = 1'b0;
    end
    if (push && (!hold_valid_q || pop)) begin
      hold_data_d  = shift_q;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign full     = hold_valid_q;
  assign rx_valid = hold_valid_q;
  assign rx_data  = hold_data_q;
`endif

  assign overrun_d = push & full & ~pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
